lfsr_uart_tx: RTL and testbench
===============================

LFSR_UART_TX -- requirements
Module: lfsr_uart_tx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 16: clk cycles per UART bit; legal range 2..1023.
REQ-002 clk  input  1  sole clock; all state on rising edge.
REQ-003 rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-004 lfsr_bits  input  8  current pseudo-random byte from the upstream LFSR stage.
REQ-005 start  input  1  request a burst; sampled only in IDLE.
REQ-006 burst_len  input  8  frames per burst, sampled with start; 0 means 256.
REQ-007 abort  input  1  synchronous burst cancel.
REQ-008 tx  output  1  UART 8N1 serial line; idle high.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  one-cycle pulse when a burst completes normally.
REQ-011 frames_left  output  9  frames remaining, including the current frame.

Function
REQ-012 The FSM SHALL have states IDLE, START_BIT, DATA, STOP_BIT.
REQ-013 IDLE: if start=1 and abort=0, SHALL load frames_left from burst_len (0 -> 256), capture lfsr_bits into shift register, enter START_BIT next cycle.
REQ-014 tx SHALL be a registered output: 1 in IDLE/STOP_BIT, 0 in START_BIT, shift_reg[0] in DATA. The first low cycle is the cycle after start is sampled.
REQ-015 Each of START_BIT, DATA per bit, and STOP_BIT SHALL last exactly CLKS_PER_BIT cycles, timed by a baud counter that reloads on every bit boundary.
REQ-016 DATA SHALL send 8 bits LSB first; 3-bit bit counter; shift right on each bit boundary.
REQ-017 Frame length SHALL be exactly 10*CLKS_PER_BIT cycles.
REQ-018 At end of STOP_BIT with frames_left>1: decrement frames_left, capture fresh lfsr_bits, enter START_BIT with zero idle gap.
REQ-019 At end of STOP_BIT with frames_left=1: frames_left->0, pulse done for one cycle, enter IDLE.
REQ-020 start asserted while busy SHALL be ignored, with no queueing.
REQ-021 abort=1 in any non-IDLE state SHALL force IDLE next cycle: tx=1, frames_left=0, no done. abort has priority over start and over the STOP_BIT completion.
REQ-022 lfsr_bits SHALL be sampled only at frame start; changes mid-frame SHALL NOT affect the transmitted byte.
REQ-023 The baud counter SHALL be ceil(log2(CLKS_PER_BIT)) bits wide with no overflow at maximum CLKS_PER_BIT.

Reset
REQ-024 Asserting rst SHALL immediately set: state=IDLE, tx=1, busy=0, done=0, frames_left=0, shift register=0, counters=0.
REQ-025 rst asserted mid-frame SHALL abandon the frame with no done pulse; after deassertion the block waits in IDLE for start.

Structure
REQ-026 Package lfsr_uart_pkg SHALL hold the state enum typedef, DATA_BITS=8, and the frames_left width constant.
REQ-027 Sub-module lfsr_baud_gen (parameter CLKS_PER_BIT; inputs clk, rst, clear; output bit_tick) SHALL generate the bit-boundary strobe. All other logic SHALL be in lfsr_uart_tx.

Verification (CLKS_PER_BIT=4)
REQ-028 lfsr_bits=8'hA5, burst_len=1, start pulse at cycle 0 -> tx bit sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles, over cycles 1-40; done pulse at cycle 40; busy falls at cycle 41.
REQ-029 burst_len=3, lfsr_bits changed every cycle -> 3 back-to-back frames (120 cycles, no idle gap); each byte equals lfsr_bits at its frame-start capture; frames_left steps 3,2,1,0.
REQ-030 burst_len=0 -> exactly 256 frames, frames_left starts at 256, one done pulse.
REQ-031 start re-pulsed at cycle 10 of a 1-frame burst -> ignored; exactly one frame and one done.
REQ-032 abort asserted during DATA bit 3 -> tx=1 and busy=0 on the next cycle; frames_left=0; no done.
REQ-033 rst asserted at cycle 17 of a frame -> tx=1 asynchronously, all outputs at reset values; a new start after release sends a clean full frame.

Source files
------------

// File: rtl/lfsr_uart_tx_pkg.sv
// Shared types and constants for the LFSR-fed UART burst transmitter.
package lfsr_uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int BIT_CNT_W = $clog2(DATA_BITS);
  localparam int FRAMES_W  = 9;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START_BIT = 2'd1,
    DATA      = 2'd2,
    STOP_BIT  = 2'd3
  } state_t;

endpackage

// File: rtl/lfsr_uart_tx_if.sv
// Control/status bundle between the burst requester and the UART transmitter.
interface lfsr_uart_tx_if;
  import lfsr_uart_pkg::*;

  logic [DATA_BITS-1:0] lfsr_bits;
  logic                 start;
  logic [7:0]           burst_len;
  logic                 abort;
  logic                 tx;
  logic                 busy;
  logic                 done;
  logic [FRAMES_W-1:0]  frames_left;

  modport master (
    output lfsr_bits, start, burst_len, abort,
    input  tx, busy, done, frames_left
  );

  modport slave (
    input  lfsr_bits, start, burst_len, abort,
    output tx, busy, done, frames_left
  );

endinterface

// File: rtl/lfsr_uart_tx_baud_gen.sv
// Bit-period timer: strobes bit_tick on the last clock of every UART bit.
module lfsr_baud_gen #(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_tick
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign bit_tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear || bit_tick) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/lfsr_uart_tx.sv
// Sends bursts of 8N1 frames, each carrying the LFSR byte present at its frame start.
module lfsr_uart_tx
  import lfsr_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic           clk,
  input  logic           rst,
  lfsr_uart_tx_if.slave  bus
);

  state_t                state_q, state_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [FRAMES_W-1:0]   frames_q, frames_d;
  logic                  tx_q, tx_d;
  logic                  done_pulse;
  logic                  bit_tick;

  lfsr_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk      (clk),
    .rst      (rst),
    .clear    (state_q == IDLE),
    .bit_tick (bit_tick)
  );

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    frames_d   = frames_q;
    done_pulse = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d   = START_BIT;
          frames_d  = (bus.burst_len == 8'd0) ? FRAMES_W'(256) : FRAMES_W'(bus.burst_len);
          shift_d   = bus.lfsr_bits;
          bit_cnt_d = '0;
        end
      end
      START_BIT: begin
        if (bit_tick) state_d = DATA;
      end
      DATA: begin
        if (bit_tick) begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BIT_CNT_W'(DATA_BITS - 1)) state_d = STOP_BIT;
        end
      end
      STOP_BIT: begin
        if (bit_tick) begin
          if (frames_q > FRAMES_W'(1)) begin
            frames_d = frames_q - 1'b1;
            shift_d  = bus.lfsr_bits;
            state_d  = START_BIT;
          end else begin
            frames_d   = '0;
            done_pulse = 1'b1;
            state_d    = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides everything decided above, including a completing stop bit.
    if (bus.abort && (state_q != IDLE)) begin
      state_d    = IDLE;
      frames_d   = '0;
      done_pulse = 1'b0;
    end

    // tx is registered, so it is derived from where the FSM is going next.
    unique case (state_d)
      START_BIT: tx_d = 1'b0;
      DATA:      tx_d = shift_d[0];
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      frames_q  <= '0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      frames_q  <= frames_d;
      tx_q      <= tx_d;
    end
  end

  assign bus.tx          = tx_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = done_pulse;
  assign bus.frames_left = frames_q;

endmodule

// File: tb/tb_lfsr_uart_tx.sv
// Scoreboard bench for lfsr_uart_tx at CLKS_PER_BIT=4: expected bytes queued at capture, checked bit by bit.
module tb_lfsr_uart_tx;
  import lfsr_uart_pkg::*;

  localparam int CPB       = 4;
  localparam int FRAME_CYC = 10 * CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;

  lfsr_uart_tx_if bus();

  lfsr_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  function automatic logic frame_bit(input logic [7:0] b, input int c);
    if (c < CPB) return 1'b0;
    if (c < 9 * CPB) return b[3'((c - CPB) / CPB)];
    return 1'b1;
  endfunction

  // Drives one start request; returns one cycle after the sampling edge (frame cycle 1).
  task automatic start_burst(input logic [7:0] b, input logic [7:0] len);
    bus.lfsr_bits = b;
    bus.burst_len = len;
    bus.start     = 1'b1;
    @(posedge clk); #1;
    bus.start     = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    total++; if (bus.tx !== 1'b1) begin bad++; $display("FAIL %s_tx: got %b required 1", tag, bus.tx); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL %s_busy: got %b required 0", tag, bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL %s_done: got %b required 0", tag, bus.done); end
    total++; if (bus.frames_left !== 9'd0) begin bad++; $display("FAIL %s_frames_left: got %0d required 0", tag, bus.frames_left); end
  endtask

  // Checks nframes back-to-back frames starting at frame cycle 1, then the idle cycle after.
  task automatic check_burst(input int nframes, input string tag);
    logic [7:0] exp_byte;
    logic       exp_tx;
    logic       exp_done;
    logic [8:0] exp_fl;
    for (int f = 0; f < nframes; f++) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++; $display("FAIL %s_scoreboard: got empty queue at frame %0d required a byte", tag, f);
        exp_byte = '0;
      end else begin
        exp_byte = exp_q.pop_front();
      end
      for (int c = 0; c < FRAME_CYC; c++) begin
        @(negedge clk);
        exp_tx   = frame_bit(exp_byte, c);
        exp_done = (f == nframes - 1) && (c == FRAME_CYC - 1);
        exp_fl   = 9'(nframes - f);
        total++; if (bus.tx !== exp_tx) begin bad++; $display("FAIL %s_tx f%0d c%0d: got %b required %b", tag, f, c, bus.tx, exp_tx); end
        total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL %s_busy f%0d c%0d: got %b required 1", tag, f, c, bus.busy); end
        total++; if (bus.done !== exp_done) begin bad++; $display("FAIL %s_done f%0d c%0d: got %b required %b", tag, f, c, bus.done, exp_done); end
        total++; if (bus.frames_left !== exp_fl) begin bad++; $display("FAIL %s_frames_left f%0d c%0d: got %0d required %0d", tag, f, c, bus.frames_left, exp_fl); end
      end
    end
    @(negedge clk);
    check_idle({tag, "_end"});
  endtask

  task automatic test_reset;
    bus.lfsr_bits = '0;
    bus.burst_len = '0;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    rst           = 1'b1;
    @(negedge clk);
    check_idle("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_idle("post_reset");
  endtask

  task automatic test_single_frame;
    exp_q.push_back(8'hA5);
    start_burst(8'hA5, 8'd1);
    check_burst(1, "single");
  endtask

  task automatic test_back_to_back;
    fork
      begin
        for (int k = 0; k < 3 * FRAME_CYC; k++) begin
          bus.lfsr_bits = 8'(k * 37 + 11);
          bus.burst_len = 8'd3;
          bus.start     = (k == 0);
          if ((k % FRAME_CYC) == 0) exp_q.push_back(bus.lfsr_bits);
          @(posedge clk); #1;
        end
      end
      begin
        @(posedge clk);
        check_burst(3, "b2b");
      end
    join
  endtask

  task automatic test_burst_256;
    for (int i = 0; i < 256; i++) exp_q.push_back(8'h5A);
    start_burst(8'h5A, 8'd0);
    check_burst(256, "b256");
  endtask

  task automatic test_start_ignored;
    exp_q.push_back(8'h3C);
    start_burst(8'h3C, 8'd1);
    fork
      begin
        repeat (9) @(posedge clk);
        #1;
        bus.start     = 1'b1;
        bus.lfsr_bits = 8'hFF;
        @(posedge clk); #1;
        bus.start     = 1'b0;
      end
      check_burst(1, "restart");
    join
    for (int c = 0; c < FRAME_CYC; c++) begin
      @(negedge clk);
      check_idle("restart_quiet");
    end
  endtask

  task automatic test_abort;
    logic [7:0] exp_byte;
    exp_q.push_back(8'hE7);
    start_burst(8'hE7, 8'd2);
    exp_byte = exp_q.pop_front();
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      total++; if (bus.tx !== frame_bit(exp_byte, c)) begin bad++; $display("FAIL abort_pre_tx c%0d: got %b required %b", c, bus.tx, frame_bit(exp_byte, c)); end
      total++; if (bus.frames_left !== 9'd2) begin bad++; $display("FAIL abort_pre_frames_left c%0d: got %0d required 2", c, bus.frames_left); end
    end
    @(posedge clk); #1;
    bus.abort = 1'b1;
    @(negedge clk);
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL abort_cycle_busy: got %b required 1", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL abort_cycle_done: got %b required 0", bus.done); end
    @(posedge clk); #1;
    bus.abort = 1'b0;
    @(negedge clk);
    check_idle("abort_next");
    for (int c = 0; c < FRAME_CYC; c++) begin
      @(negedge clk);
      check_idle("abort_quiet");
    end
    bus.abort = 1'b1;
    start_burst(8'h81, 8'd1);
    bus.abort = 1'b0;
    @(negedge clk);
    check_idle("abort_with_start");
  endtask

  task automatic test_reset_midframe;
    exp_q.push_back(8'hC4);
    start_burst(8'hC4, 8'd1);
    void'(exp_q.pop_front());
    repeat (16) @(negedge clk);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check_idle("async_rst");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_idle("rst_release");
    end
    @(posedge clk); #1;
    exp_q.push_back(8'h96);
    start_burst(8'h96, 8'd1);
    check_burst(1, "after_rst");
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_start_ignored();
    test_abort();
    test_reset_midframe();
    test_burst_256();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_leftover: got %0d bytes required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
